// File: rtl/xy_addr_gen_pkg.sv
// Shared definitions for the 2-D source-address generator: FSM encoding,
// edge-mode constants and the default video base address.
package xy_addr_gen_pkg;

    // Request sequencing states (2-bit encoding)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REMAP = 2'd1,
        ADDR  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Out-of-frame resolution modes
    localparam logic EDGE_CLAMP = 1'b0;
    localparam logic EDGE_WRAP  = 1'b1;

    // Byte address of pixel (0,0) used by the compensation blocks
    localparam logic [31:0] VIDEO_BASE_ADDR = 32'h3FFE_A000;

endpackage : xy_addr_gen_pkg

// File: rtl/xy_addr_gen_axis_remap.sv
// Single-axis source remap: saturates the signed offset to +/-(LIMIT-1),
// adds it to the counter, flags out-of-range results and resolves them by
// clamping or wrapping. Purely combinational; the parent registers outputs.
module axis_remap #(
    parameter int LIMIT = 640,
    parameter int OFF_W = 12
) (
    input  logic [10:0]      i_cnt,
    input  logic [OFF_W-1:0] i_off,
    input  logic             i_wrap,
    output logic [12:0]      o_src,
    output logic             o_oob
);

    // Working width for the saturation compare: wide enough for both the
    // offset and the 13-bit source sum.
    localparam int EW = (OFF_W > 12) ? OFF_W : 13;

    localparam logic signed [EW-1:0] LIM_M1_P = EW'(LIMIT - 1);
    localparam logic signed [EW-1:0] LIM_M1_N = EW'(-(LIMIT - 1));
    localparam logic signed [12:0]   LIM_S    = 13'(LIMIT);
    localparam logic signed [12:0]   LIM_M1_S = 13'(LIMIT - 1);

    logic signed [EW-1:0] off_ext_s;
    logic signed [EW-1:0] off_sat_s;
    logic signed [12:0]   src_s;
    logic                 below_s;
    logic                 above_s;
    logic signed [12:0]   rem_s;

    assign off_ext_s = EW'($signed(i_off));

    // Saturate the offset so a single correction step always suffices
    always_comb begin
        off_sat_s = off_ext_s;
        if (off_ext_s > LIM_M1_P) begin
            off_sat_s = LIM_M1_P;
        end else if (off_ext_s < LIM_M1_N) begin
            off_sat_s = LIM_M1_N;
        end else begin
            off_sat_s = off_ext_s;
        end
    end

    assign src_s   = $signed({2'b00, i_cnt}) + $signed(off_sat_s[12:0]);
    assign below_s = src_s[12];
    assign above_s = (!src_s[12]) && (src_s >= LIM_S);

    // Resolve an out-of-frame source by clamping to the edge or wrapping once
    always_comb begin
        rem_s = src_s;
        if (below_s) begin
            if (i_wrap) begin
                rem_s = src_s + LIM_S;
            end else begin
                rem_s = 13'sd0;
            end
        end else if (above_s) begin
            if (i_wrap) begin
                rem_s = src_s - LIM_S;
            end else begin
                rem_s = LIM_M1_S;
            end
        end else begin
            rem_s = src_s;
        end
    end

    assign o_src = rem_s;
    assign o_oob = below_s | above_s;

endmodule : axis_remap

// File: rtl/xy_addr_gen.sv
// 2-D source-address generator: captures a request, remaps both axes
// against the visible frame, then forms the MPMC byte address with shifts.
// Fixed three-cycle latency from acceptance to the o_valid pulse.
module xy_addr_gen
    import xy_addr_gen_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = VIDEO_BASE_ADDR,
    parameter int          LINE_PIXELS     = 1024,
    parameter int          BYTES_PER_PIXEL = 4,
    parameter int          FRAME_W         = 640,
    parameter int          FRAME_H         = 480,
    parameter int          OFF_W           = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req,
    input  logic [10:0]      i_x_cnt,
    input  logic [10:0]      i_y_cnt,
    input  logic [OFF_W-1:0] i_x_off,
    input  logic [OFF_W-1:0] i_y_off,
    input  logic             i_edge_mode,
    output logic             o_ready,
    output logic             o_valid,
    output logic [31:0]      o_addr,
    output logic             o_oob
);

    localparam int LINE_SH = $clog2(LINE_PIXELS);
    localparam int PIX_SH  = $clog2(BYTES_PER_PIXEL);

    state_t state_r;
    state_t state_nxt_s;

    logic             accept_s;
    logic [10:0]      x_cnt_r;
    logic [10:0]      y_cnt_r;
    logic [OFF_W-1:0] x_off_r;
    logic [OFF_W-1:0] y_off_r;
    logic             edge_r;

    logic [12:0] src_x_s;
    logic [12:0] src_y_s;
    logic        oob_x_s;
    logic        oob_y_s;
    logic [12:0] src_x_r;
    logic [12:0] src_y_r;
    logic        oob_x_r;
    logic        oob_y_r;

    logic [31:0] pix_idx_s;
    logic [31:0] addr_s;

    logic        ready_r;
    logic        valid_r;
    logic [31:0] addr_r;
    logic        oob_r;

    assign accept_s = i_req & ready_r;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a request in DONE chains straight into REMAP
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_req) begin
                    state_nxt_s = REMAP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REMAP:   state_nxt_s = ADDR;
            ADDR:    state_nxt_s = DONE;
            DONE: begin
                if (i_req) begin
                    state_nxt_s = REMAP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Capture all request fields on acceptance; ignore inputs otherwise
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x_cnt_r <= 11'd0;
            y_cnt_r <= 11'd0;
            x_off_r <= '0;
            y_off_r <= '0;
            edge_r  <= EDGE_CLAMP;
        end else if (accept_s) begin
            x_cnt_r <= i_x_cnt;
            y_cnt_r <= i_y_cnt;
            x_off_r <= i_x_off;
            y_off_r <= i_y_off;
            edge_r  <= i_edge_mode;
        end
    end

    axis_remap #(
        .LIMIT (FRAME_W),
        .OFF_W (OFF_W)
    ) u_remap_x (
        .i_cnt  (x_cnt_r),
        .i_off  (x_off_r),
        .i_wrap (edge_r == EDGE_WRAP),
        .o_src  (src_x_s),
        .o_oob  (oob_x_s)
    );

    axis_remap #(
        .LIMIT (FRAME_H),
        .OFF_W (OFF_W)
    ) u_remap_y (
        .i_cnt  (y_cnt_r),
        .i_off  (y_off_r),
        .i_wrap (edge_r == EDGE_WRAP),
        .o_src  (src_y_s),
        .o_oob  (oob_y_s)
    );

    // Register remapped coordinates at the end of REMAP
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            src_x_r <= 13'd0;
            src_y_r <= 13'd0;
            oob_x_r <= 1'b0;
            oob_y_r <= 1'b0;
        end else if (state_r == REMAP) begin
            src_x_r <= src_x_s;
            src_y_r <= src_y_s;
            oob_x_r <= oob_x_s;
            oob_y_r <= oob_y_s;
        end
    end

    // Address formation: stride and pixel size are powers of two, so shifts
    assign pix_idx_s = (32'(src_y_r) << LINE_SH) + 32'(src_x_r);
    assign addr_s    = BASE_ADDR + (pix_idx_s << PIX_SH);

    // Output registers: address/flag load at the end of ADDR and hold until the next DONE
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            addr_r  <= 32'd0;
            oob_r   <= 1'b0;
        end else begin
            ready_r <= (state_nxt_s == IDLE) || (state_nxt_s == DONE);
            valid_r <= (state_r == ADDR);
            if (state_r == ADDR) begin
                addr_r <= addr_s;
                oob_r  <= oob_x_r | oob_y_r;
            end
        end
    end

    assign o_ready = ready_r;
    assign o_valid = valid_r;
    assign o_addr  = addr_r;
    assign o_oob   = oob_r;

endmodule : xy_addr_gen

// File: tb/tb_xy_addr_gen.sv
// Directed self-checking bench for xy_addr_gen with default parameters.
// Cycle n is the interval after the n-th rising edge following acceptance;
// outputs are sampled on the falling edge.
module tb_xy_addr_gen;

    logic        i_clk;
    logic        i_rst;
    logic        i_req;
    logic [10:0] i_x_cnt;
    logic [10:0] i_y_cnt;
    logic [11:0] i_x_off;
    logic [11:0] i_y_off;
    logic        i_edge_mode;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_addr;
    logic        o_oob;

    int total;
    int bad;

    xy_addr_gen dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_x_cnt     (i_x_cnt),
        .i_y_cnt     (i_y_cnt),
        .i_x_off     (i_x_off),
        .i_y_off     (i_y_off),
        .i_edge_mode (i_edge_mode),
        .o_ready     (o_ready),
        .o_valid     (o_valid),
        .o_addr      (o_addr),
        .o_oob       (o_oob)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [10:0] x, input logic [10:0] y,
                          input logic [11:0] dx, input logic [11:0] dy, input logic m);
        i_x_cnt     = x;
        i_y_cnt     = y;
        i_x_off     = dx;
        i_y_off     = dy;
        i_edge_mode = m;
    endtask

    // Single transaction from IDLE; junk inputs in cycle 1 must be ignored
    task automatic txn(input string tag, input logic [10:0] x, input logic [10:0] y,
                       input logic [11:0] dx, input logic [11:0] dy, input logic m,
                       input logic [31:0] exp_addr, input logic exp_oob);
        set_in(x, y, dx, dy, m);
        i_req = 1'b1;
        chk({tag, ".rdy0"}, 32'(o_ready), 32'd1);
        tick();
        i_req = 1'b0;
        set_in(11'd123, 11'd45, 12'h7FF, 12'h800, ~m);
        chk({tag, ".v1"}, 32'(o_valid), 32'd0);
        chk({tag, ".rdy1"}, 32'(o_ready), 32'd0);
        tick();
        chk({tag, ".v2"}, 32'(o_valid), 32'd0);
        tick();
        chk({tag, ".v3"}, 32'(o_valid), 32'd1);
        chk({tag, ".addr"}, o_addr, exp_addr);
        chk({tag, ".oob"}, 32'(o_oob), 32'(exp_oob));
        tick();
        chk({tag, ".v4"}, 32'(o_valid), 32'd0);
        chk({tag, ".hold"}, o_addr, exp_addr);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        i_rst = 1'b1;
        i_req = 1'b0;
        set_in(11'd0, 11'd0, 12'd0, 12'd0, 1'b0);
        tick();
        tick();
        i_rst = 1'b0;
        chk("reset.ready", 32'(o_ready), 32'd1);
        chk("reset.valid", 32'(o_valid), 32'd0);
        chk("reset.addr", o_addr, 32'd0);
        chk("reset.oob", 32'(o_oob), 32'd0);
        tick();

        txn("zero",      11'd10,  11'd20,  12'd0,    12'd0,    1'b0, 32'h3FFF_E028, 1'b0);
        txn("topclamp",  11'd0,   11'd5,   12'd0,    -12'sd8,  1'b0, 32'h3FFE_A000, 1'b1);
        txn("botclamp",  11'd0,   11'd479, 12'd0,    12'd3,    1'b0, 32'h401C_9000, 1'b1);
        txn("hwrap",     11'd630, 11'd0,   12'd20,   12'd0,    1'b1, 32'h3FFE_A028, 1'b1);
        txn("satpos",    11'd0,   11'd0,   12'd2047, 12'd0,    1'b0, 32'h3FFE_A9FC, 1'b0);
        txn("satneg",    11'd700, 11'd0,   12'h800,  12'd0,    1'b0, 32'h3FFE_A0F4, 1'b0);
        txn("cntover",   11'd700, 11'd0,   12'd0,    12'd0,    1'b0, 32'h3FFE_A9FC, 1'b1);
        txn("vwrap",     11'd0,   11'd2,   12'd0,    -12'sd5,  1'b1, 32'h401C_7000, 1'b1);

        // Request held high: results in cycles 3, 6, 9; x changes before the cycle-3 accept
        set_in(11'd10, 11'd20, 12'd0, 12'd0, 1'b0);
        i_req = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            chk($sformatf("held.v%0d", c), 32'(o_valid), ((c % 3) == 0) ? 32'd1 : 32'd0);
            if (c == 3) begin
                chk("held.a3", o_addr, 32'h3FFF_E028);
                set_in(11'd11, 11'd20, 12'd0, 12'd0, 1'b0);
            end
            if (c == 6) chk("held.a6", o_addr, 32'h3FFF_E02C);
            if (c == 9) begin
                chk("held.a9", o_addr, 32'h3FFF_E02C);
                i_req = 1'b0;
            end
        end
        tick();
        chk("held.idle.rdy", 32'(o_ready), 32'd1);
        chk("held.idle.v", 32'(o_valid), 32'd0);

        // Request pulsed in cycle 1 is dropped
        set_in(11'd0, 11'd0, 12'd0, 12'd0, 1'b0);
        i_req = 1'b1;
        tick();
        set_in(11'd5, 11'd5, 12'd0, 12'd0, 1'b0);
        tick();
        i_req = 1'b0;
        tick();
        chk("pulse.v3", 32'(o_valid), 32'd1);
        chk("pulse.a3", o_addr, 32'h3FFE_A000);
        for (int c = 4; c <= 7; c++) begin
            tick();
            chk($sformatf("pulse.v%0d", c), 32'(o_valid), 32'd0);
        end

        // Reset during cycle 2 discards the in-flight request
        set_in(11'd10, 11'd20, 12'd0, 12'd0, 1'b0);
        i_req = 1'b1;
        tick();
        i_req = 1'b0;
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("rst.ready", 32'(o_ready), 32'd1);
        chk("rst.valid", 32'(o_valid), 32'd0);
        chk("rst.addr", o_addr, 32'd0);
        chk("rst.oob", 32'(o_oob), 32'd0);
        for (int c = 4; c <= 6; c++) begin
            tick();
            chk($sformatf("rst.v%0d", c), 32'(o_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_xy_addr_gen
